// File: rtl/multiexp_kernel_axi_read_master.sv
// AXI4 read master: splits a byte transfer into fixed-length bursts and streams R data out.
// Optional sticky read-error flag enabled by defining MULTIEXP_KERNEL_RD_ERR_CHECK_EN.
module multiexp_kernel_axi_read_master #(
  parameter int C_ADDR_WIDTH      = 64,
  parameter int C_DATA_WIDTH      = 512,
  parameter int C_XFER_SIZE_WIDTH = 32,
  parameter int C_BURST_LEN       = 64,
  parameter int C_MAX_OUTSTANDING = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ctrl_start,
  input  logic [C_ADDR_WIDTH-1:0]      ctrl_addr_offset,
  input  logic [C_XFER_SIZE_WIDTH-1:0] ctrl_xfer_size_in_bytes,
  output logic                         ctrl_done,
  output logic                         ctrl_busy,
  output logic                         m_axi_arvalid,
  input  logic                         m_axi_arready,
  output logic [C_ADDR_WIDTH-1:0]      m_axi_araddr,
  output logic [7:0]                   m_axi_arlen,
  input  logic                         m_axi_rvalid,
  output logic                         m_axi_rready,
  input  logic [C_DATA_WIDTH-1:0]      m_axi_rdata,
  input  logic                         m_axi_rlast,
  input  logic [1:0]                   m_axi_rresp,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic [C_DATA_WIDTH-1:0]      m_axis_tdata,
  output logic                         m_axis_tlast,
  output logic                         rd_error
);

  localparam int BYTES  = C_DATA_WIDTH / 8;
  localparam int BSHIFT = $clog2(BYTES);
  localparam int BW     = C_XFER_SIZE_WIDTH + 1;
  localparam int OW     = $clog2(C_MAX_OUTSTANDING + 1);
  localparam logic [C_ADDR_WIDTH-1:0] ADDR_STEP =
    C_ADDR_WIDTH'(C_BURST_LEN * BYTES);
  localparam logic [BW-1:0] BLEN       = BW'(C_BURST_LEN);
  localparam logic [7:0]    FULL_ARLEN = 8'(C_BURST_LEN - 1);
  localparam logic [OW-1:0] MAX_OS     = OW'(C_MAX_OUTSTANDING);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state_q;
  logic [C_ADDR_WIDTH-1:0] araddr_q;
  logic [7:0]              arlen_q;
  logic [7:0]              final_arlen_q;
  logic                    arvalid_q;
  logic                    done_q;
  logic                    busy_q;
  logic [BW-1:0]           bursts_q, bursts_d;
  logic [OW-1:0]           outst_q, outst_d;

  logic [BW-1:0] beats, nbursts, rem_beats;
  logic [7:0]    final_arlen;
  logic          ar_hs, r_hs, rlast_hs, final_beat;

  // Burst plan derived from the requested byte count at start time
  always_comb begin
    beats = (BW'(ctrl_xfer_size_in_bytes) + BW'(BYTES - 1)) >> BSHIFT;
    nbursts = (beats + BLEN - BW'(1)) / BLEN;
    rem_beats = beats % BLEN;
    final_arlen = (rem_beats == '0) ? FULL_ARLEN
                                    : 8'(rem_beats - BW'(1));
  end

  assign ar_hs      = arvalid_q & m_axi_arready;
  assign r_hs       = (state_q == RUN) & m_axi_rvalid & m_axis_tready;
  assign rlast_hs   = r_hs & m_axi_rlast & (outst_q != '0);
  assign final_beat = (bursts_q == '0) & (outst_q == OW'(1));

  assign m_axi_rready  = m_axis_tready;
  assign m_axis_tvalid = m_axi_rvalid & (state_q == RUN);
  assign m_axis_tdata  = m_axi_rdata;
  assign m_axis_tlast  = m_axis_tvalid & m_axi_rlast & final_beat;

  assign m_axi_arvalid = arvalid_q;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arlen   = arlen_q;
  assign ctrl_done     = done_q;
  assign ctrl_busy     = busy_q;

  // Remaining-burst and in-flight counters after this cycle's handshakes
  always_comb begin
    bursts_d = ar_hs ? bursts_q - BW'(1) : bursts_q;
    outst_d  = outst_q;
    if (ar_hs && !rlast_hs)
      outst_d = outst_q + OW'(1);
    else if (!ar_hs && rlast_hs)
      outst_d = outst_q - OW'(1);
  end

  // Control FSM with registered AR channel and done/busy outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      araddr_q      <= '0;
      arlen_q       <= '0;
      final_arlen_q <= '0;
      arvalid_q     <= 1'b0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
      bursts_q      <= '0;
      outst_q       <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (ctrl_start) begin
            araddr_q      <= ctrl_addr_offset;
            bursts_q      <= nbursts;
            final_arlen_q <= final_arlen;
            outst_q       <= '0;
            if (ctrl_xfer_size_in_bytes == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q   <= RUN;
              busy_q    <= 1'b1;
              arvalid_q <= 1'b1;
              arlen_q   <= (nbursts == BW'(1)) ? final_arlen
                                               : FULL_ARLEN;
            end
          end
        end
        RUN: begin
          bursts_q  <= bursts_d;
          outst_q   <= outst_d;
          arvalid_q <= (bursts_d != '0) && (outst_d < MAX_OS);
          arlen_q   <= (bursts_d == BW'(1)) ? final_arlen_q
                                            : FULL_ARLEN;
          if (ar_hs)
            araddr_q <= araddr_q + ADDR_STEP;
          if (rlast_hs && final_beat) begin
            state_q   <= DONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            arvalid_q <= 1'b0;
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef MULTIEXP_KERNEL_RD_ERR_CHECK_EN
  logic err_q;

  // Sticky flag for any non-OKAY response, cleared by a new transfer
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_q <= 1'b0;
    else if (state_q == IDLE && ctrl_start)
      err_q <= 1'b0;
    else if (r_hs && m_axi_rresp != 2'b00)
      err_q <= 1'b1;
  end

  assign rd_error = err_q;
`else
  logic unused_rresp;
  assign unused_rresp = ^m_axi_rresp;
  assign rd_error = 1'b0;
`endif

endmodule

// File: tb/tb_multiexp_kernel_axi_read_master.sv
// Bench for multiexp_kernel_axi_read_master.
// Randomised AXI slave plus transfer-level reference model.
`timescale 1ns/1ps
module tb_multiexp_kernel_axi_read_master;
  localparam int AW = 64;
  localparam int DW = 512;
  localparam int SW = 32;
  localparam int BL = 64;
  localparam int MOS = 2;
  localparam int BYTES = DW / 8;
`ifdef MULTIEXP_KERNEL_RD_ERR_CHECK_EN
  localparam bit ERRCHK = 1'b1;
`else
  localparam bit ERRCHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ctrl_start = 1'b0;
  logic [AW-1:0] ctrl_addr_offset = '0;
  logic [SW-1:0] ctrl_xfer_size_in_bytes = '0;
  logic ctrl_done, ctrl_busy;
  logic m_axi_arvalid;
  logic m_axi_arready = 1'b0;
  logic [AW-1:0] m_axi_araddr;
  logic [7:0] m_axi_arlen;
  logic m_axi_rvalid = 1'b0;
  logic m_axi_rready;
  logic [DW-1:0] m_axi_rdata = '0;
  logic m_axi_rlast = 1'b0;
  logic [1:0] m_axi_rresp = 2'b00;
  logic m_axis_tvalid;
  logic m_axis_tready = 1'b0;
  logic [DW-1:0] m_axis_tdata;
  logic m_axis_tlast;
  logic rd_error;

  always #5 clk = ~clk;

  multiexp_kernel_axi_read_master #(
    .C_ADDR_WIDTH(AW), .C_DATA_WIDTH(DW),
    .C_XFER_SIZE_WIDTH(SW), .C_BURST_LEN(BL),
    .C_MAX_OUTSTANDING(MOS)
  ) u_dut (
    .clk(clk), .rst(rst),
    .ctrl_start(ctrl_start),
    .ctrl_addr_offset(ctrl_addr_offset),
    .ctrl_xfer_size_in_bytes(ctrl_xfer_size_in_bytes),
    .ctrl_done(ctrl_done), .ctrl_busy(ctrl_busy),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rlast(m_axi_rlast),
    .m_axi_rresp(m_axi_rresp),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
    .rd_error(rd_error)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [63:0] addr;
    int len;
    int rdy;
  } burst_t;

  typedef struct {
    int unsigned size;
    logic [63:0] off;
    int arp, tp, rdly, bad;
    bit spur;
    int e_ar, e_beats, e_last;
  } vec_t;

  // One transfer: start, play slave, check against the transfer model
  task automatic run_xfer(input int unsigned size, input logic [63:0] off,
                          input int arp, input int tp, input int rdly,
                          input int bad, input bit spur,
                          output int n_ar, output int n_beat,
                          output int max_os, output int last_len);
    int tot, nb, os, cyc, sl_beat, sl_g;
    logic [63:0] ea[$];
    int el[$];
    burst_t sq[$];
    burst_t b;
    bit exp_done, exp_err, done_seen;
    bit nx_arr, nx_tr, nx_rv, nx_rl, nx_st;
    logic [DW-1:0] nx_rd;
    logic [1:0] nx_rr;
    tot = int'((size + 63) / 64);
    nb = (tot + BL - 1) / BL;
    for (int i = 0; i < nb; i++) begin
      ea.push_back(off + 64'(i * BL * BYTES));
      el.push_back(i == nb - 1 ? tot - (nb - 1) * BL - 1 : BL - 1);
    end
    n_ar = 0; n_beat = 0; max_os = 0; last_len = -1;
    os = 0; sl_beat = 0; sl_g = 0; cyc = 0;
    exp_err = 1'b0; done_seen = 1'b0; exp_done = (size == 0);
    @(posedge clk); #1;
    ctrl_start = 1'b1;
    ctrl_addr_offset = off;
    ctrl_xfer_size_in_bytes = size;
    @(posedge clk); #1;
    ctrl_start = 1'b0;
    ctrl_addr_offset = '0;
    ctrl_xfer_size_in_bytes = '0;
    while (cyc < 20000 && !done_seen) begin
      @(negedge clk);
      if (cyc == 0) chk("first_arvalid", m_axi_arvalid, size != 0);
      chk("done", ctrl_done, exp_done);
      chk("busy", ctrl_busy, !exp_done);
      chk("rd_error", rd_error, exp_err);
      if (os == MOS) chk("ar_limit", m_axi_arvalid, 1'b0);
      chk("rready", m_axi_rready, m_axis_tready);
      chk("tvalid", m_axis_tvalid, m_axi_rvalid && !exp_done);
      done_seen = exp_done;
      exp_done = 1'b0;
      if (m_axi_arvalid && m_axi_arready) begin
        if (ea.size() == 0) begin
          chk("ar_extra", 1'b1, 1'b0);
        end else begin
          chk("araddr", m_axi_araddr, ea.pop_front());
          chk("arlen", m_axi_arlen, el.pop_front());
        end
        b.addr = m_axi_araddr;
        b.len = int'(m_axi_arlen);
        b.rdy = cyc + rdly;
        sq.push_back(b);
        last_len = int'(m_axi_arlen);
        n_ar++;
        os++;
      end
      if (os > max_os) max_os = os;
      if (m_axi_rvalid && m_axis_tready) begin
        chk("tdata", m_axis_tdata, {8{off + 64'(n_beat * BYTES)}});
        chk("tlast", m_axis_tlast, n_beat == tot - 1);
        if (m_axi_rresp != 2'b00) exp_err = ERRCHK;
        n_beat++;
        sl_g++;
        if (m_axi_rlast) begin
          void'(sq.pop_front());
          sl_beat = 0;
          os--;
        end else begin
          sl_beat++;
        end
        if (n_beat == tot) exp_done = 1'b1;
      end
      nx_arr = $urandom_range(99) < arp;
      nx_tr = $urandom_range(99) < tp;
      nx_st = spur && cyc == 3;
      if (m_axi_rvalid && !m_axis_tready) begin
        nx_rv = m_axi_rvalid; nx_rl = m_axi_rlast;
        nx_rd = m_axi_rdata; nx_rr = m_axi_rresp;
      end else if (sq.size() > 0 && cyc >= sq[0].rdy &&
                   $urandom_range(3) != 0) begin
        nx_rv = 1'b1;
        nx_rd = {8{sq[0].addr + 64'(sl_beat * BYTES)}};
        nx_rl = sl_beat == sq[0].len;
        nx_rr = (sl_g == bad) ? 2'b10 : 2'b00;
      end else begin
        nx_rv = 1'b0; nx_rl = 1'b0; nx_rd = '0; nx_rr = 2'b00;
      end
      @(posedge clk); #1;
      m_axi_arready = nx_arr;
      m_axis_tready = nx_tr;
      m_axi_rvalid = nx_rv;
      m_axi_rlast = nx_rl;
      m_axi_rdata = nx_rd;
      m_axi_rresp = nx_rr;
      ctrl_start = nx_st;
      ctrl_addr_offset = nx_st ? 64'hdead_0000 : '0;
      ctrl_xfer_size_in_bytes = nx_st ? 32'd64 : '0;
      cyc++;
    end
    if (!done_seen) chk("timeout", 1'b0, 1'b1);
    m_axi_rvalid = 1'b0;
    m_axi_rlast = 1'b0;
    m_axi_rresp = 2'b00;
    ctrl_start = 1'b0;
  endtask

  vec_t vt[8];
  int n_ar, n_beat, max_os, last_len;
  int tot, nb;
  int unsigned rsz;
  logic [63:0] roff;

  initial begin
    vt[0] = '{4096, 64'h1000_0000, 100, 100, 0, -1, 1'b0, 1, 64, 63};
    vt[1] = '{8256, 64'h40, 100, 100, 0, -1, 1'b0, 3, 129, 0};
    vt[2] = '{32768, 64'h8000, 100, 100, 20, -1, 1'b0, 8, 512, 63};
    vt[3] = '{0, 64'h100, 100, 100, 0, -1, 1'b0, 0, 0, -1};
    vt[4] = '{100, 64'h80, 70, 60, 3, -1, 1'b1, 1, 2, 1};
    vt[5] = '{4097, 64'h0, 50, 50, 5, -1, 1'b0, 2, 65, 0};
    vt[6] = '{64, 64'hffc0, 100, 100, 0, -1, 1'b0, 1, 1, 0};
    vt[7] = '{12288, 64'h4000, 80, 90, 2, 10, 1'b1, 3, 192, 63};

    repeat (2) @(negedge clk);
    chk("rst_done", ctrl_done, 1'b0);
    chk("rst_busy", ctrl_busy, 1'b0);
    chk("rst_arvalid", m_axi_arvalid, 1'b0);
    chk("rst_araddr", m_axi_araddr, 64'h0);
    chk("rst_arlen", m_axi_arlen, 8'h0);
    chk("rst_tvalid", m_axis_tvalid, 1'b0);
    chk("rst_tlast", m_axis_tlast, 1'b0);
    chk("rst_rd_error", rd_error, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_xfer(vt[i].size, vt[i].off, vt[i].arp, vt[i].tp, vt[i].rdly,
               vt[i].bad, vt[i].spur, n_ar, n_beat, max_os, last_len);
      chk($sformatf("v%0d_n_ar", i), n_ar, vt[i].e_ar);
      chk($sformatf("v%0d_n_beat", i), n_beat, vt[i].e_beats);
      chk($sformatf("v%0d_last_len", i), last_len, vt[i].e_last);
      chk($sformatf("v%0d_max_os", i), max_os <= MOS, 1'b1);
    end

    @(negedge clk);
    chk("err_sticky", rd_error, ERRCHK);

    @(posedge clk); #1;
    m_axi_rvalid = 1'b1; m_axi_rlast = 1'b1; m_axis_tready = 1'b1;
    @(negedge clk);
    chk("idle_tvalid", m_axis_tvalid, 1'b0);
    chk("idle_tlast", m_axis_tlast, 1'b0);
    chk("idle_rready", m_axi_rready, 1'b1);
    m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;

    @(posedge clk); #1;
    ctrl_start = 1'b1;
    ctrl_addr_offset = '0;
    ctrl_xfer_size_in_bytes = 32'd32768;
    m_axi_arready = 1'b1;
    @(posedge clk); #1;
    ctrl_start = 1'b0;
    ctrl_xfer_size_in_bytes = '0;
    @(posedge clk);
    @(posedge clk); #1;
    chk("pre_rst_busy", ctrl_busy, 1'b1);
    chk("pre_rst_araddr", m_axi_araddr, 64'd8192);
    chk("pre_rst_arvalid", m_axi_arvalid, 1'b0);
    chk("pre_rst_err", rd_error, 1'b0);
    m_axi_rvalid = 1'b1; m_axi_rlast = 1'b1;
    m_axi_rresp = 2'b10; m_axis_tready = 1'b1;
    #1;
    chk("pre_rst_tvalid", m_axis_tvalid, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("arst_busy", ctrl_busy, 1'b0);
    chk("arst_done", ctrl_done, 1'b0);
    chk("arst_arvalid", m_axi_arvalid, 1'b0);
    chk("arst_araddr", m_axi_araddr, 64'h0);
    chk("arst_arlen", m_axi_arlen, 8'h0);
    chk("arst_tvalid", m_axis_tvalid, 1'b0);
    chk("arst_tlast", m_axis_tlast, 1'b0);
    chk("arst_rd_error", rd_error, 1'b0);
    @(negedge clk);
    m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
    m_axi_rresp = 2'b00; m_axi_arready = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      rsz = $urandom_range(20000);
      roff = 64'($urandom_range(16'hffff)) << 6;
      tot = int'((rsz + 63) / 64);
      nb = (tot + BL - 1) / BL;
      run_xfer(rsz, roff, $urandom_range(30, 100), $urandom_range(30, 100),
               $urandom_range(0, 8), -1, 1'b0,
               n_ar, n_beat, max_os, last_len);
      chk($sformatf("r%0d_n_ar", i), n_ar, nb);
      chk($sformatf("r%0d_n_beat", i), n_beat, tot);
      chk($sformatf("r%0d_last_len", i), last_len,
          nb == 0 ? -1 : tot - (nb - 1) * BL - 1);
      chk($sformatf("r%0d_max_os", i), max_os <= MOS, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/multiexp_kernel_axi_read_master.md
# multiexp_kernel_axi_read_master

Read-side AXI4 master for the multiexp kernel: on a start pulse it splits a byte-sized transfer into fixed-length AXI4 read bursts, issues them on the AR channel with a bounded number of outstanding bursts, and forwards returned R data as an AXI4-Stream to the multiexp datapath. It sits directly upstream of the point/scalar stream consumers and owns the outstanding-burst and remaining-burst counters the kernel's control logic relies on for done detection.

## Interface
- C_ADDR_WIDTH, 64, AXI address width
- C_DATA_WIDTH, 512, AXI/AXIS data width (power of two, >= 32)
- C_XFER_SIZE_WIDTH, 32, width of byte-count input
- C_BURST_LEN, 64, beats per full burst (1..256)
- C_MAX_OUTSTANDING, 16, max read bursts in flight (>= 1)

- clk  in  1  kernel clock
- rst  in  1  asynchronous, active-high reset
- ctrl_start  in  1  single-cycle start pulse
- ctrl_addr_offset  in  C_ADDR_WIDTH  byte start address, aligned to C_DATA_WIDTH/8
- ctrl_xfer_size_in_bytes  in  C_XFER_SIZE_WIDTH  transfer size
- ctrl_done  out  1  single-cycle done pulse
- ctrl_busy  out  1  high from accepted start until done
- m_axi_arvalid  out  1; m_axi_arready  in  1
- m_axi_araddr  out  C_ADDR_WIDTH; m_axi_arlen  out  8
- m_axi_rvalid  in  1; m_axi_rready  out  1
- m_axi_rdata  in  C_DATA_WIDTH; m_axi_rlast  in  1; m_axi_rresp  in  2
- m_axis_tvalid  out  1; m_axis_tready  in  1
- m_axis_tdata  out  C_DATA_WIDTH; m_axis_tlast  out  1
- rd_error  out  1  sticky read-error flag (see Configuration)

## Operation
- States: IDLE, RUN, DONE.
- IDLE: ctrl_start latches address and size; total_beats = ceil(size / (C_DATA_WIDTH/8)); num_bursts = ceil(total_beats / C_BURST_LEN); final_len = total_beats - (num_bursts-1)*C_BURST_LEN. size 0 -> go to DONE directly, no AR issued.
- ctrl_start outside IDLE is ignored.
- RUN, AR side: arvalid asserted while bursts_remaining > 0 and outstanding < C_MAX_OUTSTANDING; arlen = C_BURST_LEN-1, last burst arlen = final_len-1; araddr advances by C_BURST_LEN*C_DATA_WIDTH/8 per AR handshake. araddr/arlen stable while arvalid && !arready.
- Outstanding counter: +1 on AR handshake, -1 on R handshake with rlast; both same cycle -> unchanged. Never exceeds C_MAX_OUTSTANDING, never underflows.
- R side: pass-through, m_axi_rready = m_axis_tready, m_axis_tvalid = m_axi_rvalid, tdata = rdata; tlast = rlast of final burst only.
- RUN -> DONE when all bursts issued, outstanding 0, final rlast accepted. DONE: ctrl_done high one cycle, then IDLE.
- Reset mid-transfer: all state cleared immediately; in-flight R beats after reset release are accepted and dropped only if they arrive (rready = tready, tvalid forced 0 in IDLE).

## Timing
- Reset values: ctrl_done 0, ctrl_busy 0, arvalid 0, araddr 0, arlen 0, tvalid 0 (derived), tlast 0, rd_error 0.
- First arvalid the cycle after the start pulse (registered).
- Back-to-back AR issue: one AR per cycle when arready held high and limit not reached.
- R path zero latency (combinational).
- ctrl_done asserts the cycle after the final rlast handshake; ctrl_busy deasserts with ctrl_done. Size 0: done the cycle after start.
- New start accepted the cycle after ctrl_done.

## Configuration
- MULTIEXP_KERNEL_RD_ERR_CHECK_EN defined: any R handshake with rresp != 0 sets rd_error (sticky until rst or next accepted start); transfer still completes normally.
- Undefined: rresp ignored, rd_error tied 0.

## Test plan
- size 4096 B, C_DATA_WIDTH 512, C_BURST_LEN 64, arready/tready always 1 -> one AR, arlen 63, 64 beats, tlast on beat 64, ctrl_done one cycle after.
- size 8256 B -> 3 ARs, arlen 63,63,0, araddr offset+0, +4096, +8192; 129 beats total.
- C_MAX_OUTSTANDING 2, size 32 KiB, R delayed 20 cycles -> arvalid drops after 2 ARs, resumes on each rlast; outstanding never > 2.
- size 0 -> no arvalid, ctrl_done the cycle after start; start during busy ignored.
- Macro defined, rresp=2 on beat 10 -> rd_error 1 from next cycle, done still pulses; rst mid-transfer -> all outputs return to reset values asynchronously.
